// File: rtl/intc_multi_pkg.sv
// Shared definitions for the multi-channel interrupt controller: CSR bus widths,
// register offsets within a bank and the bank/mask helpers.
package intc_multi_pkg;

  localparam int CSR_AW   = 5;
  localparam int CSR_DW   = 8;
  localparam int MAX_INTS = 16;

  typedef enum logic [1:0] {
    IE_OFF   = 2'd0,
    IP_OFF   = 2'd1,
    TYPE_OFF = 2'd2,
    POL_OFF  = 2'd3
  } csr_off_e;

  function automatic int calc_nbanks(input int num_ints);
    return (num_ints + 7) / 8;
  endfunction

  function automatic logic [MAX_INTS-1:0] valid_mask(input int num_ints);
    return MAX_INTS'((32'd1 << num_ints) - 32'd1);
  endfunction

endpackage

// File: rtl/intc_multi_if.sv
// Shared 5-bit CSR bus driven by the I2C slave; every register block is a slave.
interface intc_multi_if;
  import intc_multi_pkg::*;

  logic [CSR_AW-1:0] csr_a;
  logic [CSR_DW-1:0] csr_di;
  logic              csr_we;
  logic [CSR_DW-1:0] csr_do;

  modport master (output csr_a, csr_di, csr_we, input csr_do);
  modport slave  (input csr_a, csr_di, csr_we, output csr_do);
endinterface

// File: rtl/intc_multi_int_channel.sv
// One interrupt channel: input synchroniser, previous-sample flop, edge/level
// detection and the pending flop.
module int_channel #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_int,
  input  logic i_type,     // 1 = edge, 0 = level
  input  logic i_pol,      // 1 = rising/high, 0 = falling/low
  input  logic i_clr,      // write-1-to-clear strobe
  input  logic i_type_wr,  // TYPE bit written to edge this cycle
  output logic o_pending
);

  logic w_s;
  logic w_event;
  logic r_p;
  logic r_ip;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = i_int;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      // NOTE: synchroniser flops carry no reset; they flush within SYNC_STAGES clocks anyway.
      always_ff @(posedge clk) begin
        r_sync[0] <= i_int;
        for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Tracking continues through reset so a level held across reset is not an edge.
  always_ff @(posedge clk) r_p <= w_s;

  assign w_event = i_pol ? (w_s & ~r_p) : (~w_s & r_p);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                      r_ip <= 1'b0;
    else if (i_type_wr && !i_type) r_ip <= w_event;
    else if (i_type)               r_ip <= w_event | (r_ip & ~i_clr);
    else                           r_ip <= w_s ^ ~i_pol;
  end

  assign o_pending = r_ip;

endmodule

// File: rtl/intc_multi.sv
// Parametrised interrupt controller: CSR decode, IE/TYPE/POL registers,
// read mux and the registered combined irq.
module intc_multi
  import intc_multi_pkg::*;
#(
  parameter logic [4:0]  BASE_ADDR   = 5'h1c,
  parameter int          NUM_INTS    = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DFL_IE      = 16'h0,
  parameter logic [15:0] DFL_TYPE    = 16'h0,
  parameter logic [15:0] DFL_POL     = 16'h0
) (
  input  logic                clk,
  input  logic                rst,
  intc_multi_if.slave         csr,
  input  logic [NUM_INTS-1:0] i_int,
  output logic                o_irq
);

  localparam int                 NBANKS = calc_nbanks(NUM_INTS);
  localparam logic [MAX_INTS-1:0] VALID  = valid_mask(NUM_INTS);

  logic [5:0]          w_rel;
  logic                w_hit;
  logic                w_bank;
  logic                w_wr;
  csr_off_e            w_off;
  logic [MAX_INTS-1:0] w_lane;
  logic [MAX_INTS-1:0] w_wdata;
  logic [MAX_INTS-1:0] w_ip;
  logic [MAX_INTS-1:0] w_word;
  logic [NUM_INTS-1:0] w_clr;
  logic [NUM_INTS-1:0] w_type_wr;

  logic [MAX_INTS-1:0] r_ie;
  logic [MAX_INTS-1:0] r_type;
  logic [MAX_INTS-1:0] r_pol;
  logic                r_irq;

  // Addresses below the base wrap to large values and fall out of range.
  assign w_rel   = {1'b0, csr.csr_a} - {1'b0, BASE_ADDR};
  assign w_hit   = (w_rel < 6'(4 * NBANKS));
  assign w_bank  = w_rel[2];
  assign w_off   = csr_off_e'(w_rel[1:0]);
  assign w_lane  = VALID & (w_bank ? 16'hff00 : 16'h00ff);
  assign w_wdata = {2{csr.csr_di}} & w_lane;
  assign w_wr    = csr.csr_we & w_hit;

  assign w_clr     = (w_wr && w_off == IP_OFF)   ? w_wdata[NUM_INTS-1:0] : '0;
  assign w_type_wr = (w_wr && w_off == TYPE_OFF) ? w_wdata[NUM_INTS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie   <= DFL_IE   & VALID;
      r_type <= DFL_TYPE & VALID;
      r_pol  <= DFL_POL  & VALID;
    end else if (w_wr) begin
      case (w_off)
        IE_OFF:   r_ie   <= (r_ie   & ~w_lane) | w_wdata;
        TYPE_OFF: r_type <= (r_type & ~w_lane) | w_wdata;
        POL_OFF:  r_pol  <= (r_pol  & ~w_lane) | w_wdata;
        default:  ;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < MAX_INTS; i++) begin : g_ch
      if (i < NUM_INTS) begin : g_used
        int_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
          .clk       (clk),
          .rst       (rst),
          .i_int     (i_int[i]),
          .i_type    (r_type[i]),
          .i_pol     (r_pol[i]),
          .i_clr     (w_clr[i]),
          .i_type_wr (w_type_wr[i]),
          .o_pending (w_ip[i])
        );
      end else begin : g_unused
        assign w_ip[i] = 1'b0;
      end
    end
  endgenerate

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_word     = '0;
    csr.csr_do = '0;
    case (w_off)
      IE_OFF:   w_word = r_ie;
      IP_OFF:   w_word = w_ip;
      TYPE_OFF: w_word = r_type;
      POL_OFF:  w_word = r_pol;
      default:  w_word = '0;
    endcase
    if (w_hit) csr.csr_do = w_bank ? w_word[15:8] : w_word[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= |(w_ip & r_ie);
  end

  assign o_irq = r_irq;

endmodule

// File: tb/tb_intc_multi.sv
// Directed bench for intc_multi: 12 channels at base 5'h10, all edge/rising,
// only channel 11 enabled at reset.
module tb_intc_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] i_int;
  logic        o_irq;
  logic [7:0]  rd;
  int          checks = 0;
  int          errors = 0;

  intc_multi_if bus ();

  intc_multi #(
    .BASE_ADDR   (5'h10),
    .NUM_INTS    (12),
    .SYNC_STAGES (2),
    .DFL_IE      (16'h0800),
    .DFL_TYPE    (16'h0fff),
    .DFL_POL     (16'h0fff)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .csr   (bus),
    .i_int (i_int),
    .o_irq (o_irq)
  );

  always #5 clk = ~clk;

  task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.csr_a  = a;
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    @(negedge clk);
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [4:0] a, output logic [7:0] d);
    bus.csr_a = a;
    #1;
    d = bus.csr_do;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", o_irq); end
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_ip0 got %h exp 00", rd); end
    csr_read(5'h15, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_ip1 got %h exp 00", rd); end
    csr_read(5'h14, rd); checks++; if (rd !== 8'h08) begin errors++; $display("FAIL rst_ie1 got %h exp 08", rd); end
    csr_read(5'h16, rd); checks++; if (rd !== 8'h0f) begin errors++; $display("FAIL rst_type1 got %h exp 0f", rd); end
  endtask

  task automatic test_edge_latency();
    @(negedge clk); i_int[11] = 1'b1;
    @(negedge clk); i_int[11] = 1'b0;
    idle(2);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t1_irq_early got %b exp 0", o_irq); end
    csr_read(5'h15, rd); checks++; if (rd !== 8'h08) begin errors++; $display("FAIL t1_ip got %h exp 08", rd); end
    idle(1);
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t1_irq got %b exp 1", o_irq); end
    csr_write(5'h15, 8'h08);
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t1_irq_w1c_1 got %b exp 1", o_irq); end
    idle(1);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t1_irq_w1c_2 got %b exp 0", o_irq); end
    csr_read(5'h15, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t1_ip_clr got %h exp 00", rd); end
  endtask

  task automatic test_level();
    csr_write(5'h13, 8'hfe);
    csr_write(5'h12, 8'hfe);
    csr_write(5'h10, 8'h01);
    idle(3);
    csr_read(5'h11, rd); checks++; if (rd !== 8'h01) begin errors++; $display("FAIL t2_ip got %h exp 01", rd); end
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t2_irq got %b exp 1", o_irq); end
    csr_write(5'h11, 8'h01);
    idle(1);
    csr_read(5'h11, rd); checks++; if (rd !== 8'h01) begin errors++; $display("FAIL t2_ip_w1c got %h exp 01", rd); end
    i_int[0] = 1'b1;
    idle(5);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t2_irq_rel got %b exp 0", o_irq); end
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t2_ip_rel got %h exp 00", rd); end
    csr_write(5'h12, 8'hff);
    csr_write(5'h13, 8'hff);
    i_int[0] = 1'b0;
    csr_write(5'h10, 8'h00);
    idle(4);
  endtask

  task automatic test_set_wins();
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t3_ip_pre got %h exp 00", rd); end
    @(negedge clk); i_int[3] = 1'b1;
    idle(2);
    bus.csr_a = 5'h11; bus.csr_di = 8'h08; bus.csr_we = 1'b1;
    @(negedge clk); bus.csr_we = 1'b0;
    csr_read(5'h11, rd); checks++; if (rd !== 8'h08) begin errors++; $display("FAIL t3_set_wins got %h exp 08", rd); end
    csr_write(5'h11, 8'h08);
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t3_ip_clr got %h exp 00", rd); end
    i_int[3] = 1'b0;
    idle(4);
  endtask

  task automatic test_mask();
    i_int[2] = 1'b1;
    idle(6);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t4_irq_masked got %b exp 0", o_irq); end
    csr_read(5'h11, rd); checks++; if (rd !== 8'h04) begin errors++; $display("FAIL t4_ip got %h exp 04", rd); end
    csr_write(5'h10, 8'h04);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t4_irq_ie_0 got %b exp 0", o_irq); end
    idle(1);
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t4_irq_ie_1 got %b exp 1", o_irq); end
    csr_write(5'h10, 8'h00);
    csr_write(5'h11, 8'h04);
    i_int[2] = 1'b0;
    idle(4);
  endtask

  task automatic test_pol_type_change();
    i_int[5] = 1'b1;
    idle(5);
    csr_read(5'h11, rd); checks++; if (rd !== 8'h20) begin errors++; $display("FAIL t5_ip_edge got %h exp 20", rd); end
    csr_write(5'h11, 8'h20);
    csr_write(5'h13, 8'hdf);
    csr_write(5'h13, 8'hff);
    idle(4);
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t5_pol_toggle got %h exp 00", rd); end
    csr_write(5'h12, 8'hdf);
    idle(2);
    csr_read(5'h11, rd); checks++; if (rd !== 8'h20) begin errors++; $display("FAIL t5_ip_level got %h exp 20", rd); end
    csr_write(5'h12, 8'hff);
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t5_to_edge got %h exp 00", rd); end
    i_int[5] = 1'b0;
    idle(4);
  endtask

  task automatic test_reset_mid();
    csr_write(5'h13, 8'h00);
    csr_write(5'h12, 8'h00);
    csr_write(5'h10, 8'hff);
    csr_write(5'h14, 8'h00);
    idle(3);
    csr_read(5'h11, rd); checks++; if (rd !== 8'hff) begin errors++; $display("FAIL t6_ip_pre got %h exp ff", rd); end
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t6_irq_pre got %b exp 1", o_irq); end
    @(negedge clk); rst = 1'b1; i_int = 12'hfff;
    idle(4);
    rst = 1'b0;
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t6_irq_rst got %b exp 0", o_irq); end
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t6_ip_rst got %h exp 00", rd); end
    idle(6);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t6_irq_post got %b exp 0", o_irq); end
    csr_read(5'h11, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t6_ip0_post got %h exp 00", rd); end
    csr_read(5'h15, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t6_ip1_post got %h exp 00", rd); end
    csr_read(5'h10, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t6_ie0 got %h exp 00", rd); end
    csr_read(5'h14, rd); checks++; if (rd !== 8'h08) begin errors++; $display("FAIL t6_ie1 got %h exp 08", rd); end
    csr_read(5'h12, rd); checks++; if (rd !== 8'hff) begin errors++; $display("FAIL t6_type0 got %h exp ff", rd); end
    csr_read(5'h17, rd); checks++; if (rd !== 8'h0f) begin errors++; $display("FAIL t6_pol1 got %h exp 0f", rd); end
    csr_read(5'h18, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t6_oor_hi got %h exp 00", rd); end
    csr_read(5'h0f, rd); checks++; if (rd !== 8'h00) begin errors++; $display("FAIL t6_oor_lo got %h exp 00", rd); end
  endtask

  initial begin
    rst        = 1'b1;
    i_int      = '0;
    bus.csr_a  = '0;
    bus.csr_di = '0;
    bus.csr_we = 1'b0;
    idle(5);
    rst = 1'b0;
    idle(1);
    test_reset();
    test_edge_latency();
    test_level();
    test_set_wins();
    test_mask();
    test_pol_type_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
